// File: rtl/kmeans_iter_ctrl.sv
// Iteration sequencer for 1-D K-means. Streams points to an external assign unit,
// accumulates per-cluster sums/counts, divides for new centroids, and repeats until stable.
module kmeans_iter_ctrl #(
    parameter int K        = 4,
    parameter int N_POINTS = 64,
    parameter int DW       = 32,
    parameter int MAX_ITER = 16,
    localparam int AW = $clog2(N_POINTS),
    localparam int KW = $clog2(K),
    localparam int SW = DW + AW,
    localparam int CW = AW + 1,
    localparam int IW = $clog2(MAX_ITER + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            converged,
    output logic [IW-1:0]   iter_count,
    output logic            point_rd,
    output logic [AW-1:0]   point_addr,
    input  logic [DW-1:0]   point_data,
    output logic            dist_req,
    output logic [DW-1:0]   dist_point,
    input  logic            dist_ack,
    input  logic [KW-1:0]   dist_id,
    output logic            div_req,
    output logic [SW-1:0]   div_dividend,
    output logic [CW-1:0]   div_divisor,
    input  logic            div_ack,
    input  logic [DW-1:0]   div_quot,
    input  logic [K*DW-1:0] cent_q,
    output logic [K-1:0]    cent_we,
    output logic [DW-1:0]   cent_wdata
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_WAITD  = 3'd2;
    localparam logic [2:0] S_DIST   = 3'd3;
    localparam logic [2:0] S_DIVREQ = 3'd4;
    localparam logic [2:0] S_UPDATE = 3'd5;
    localparam logic [2:0] S_CHECK  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam logic [AW-1:0] LAST_IDX = AW'(N_POINTS - 1);
    localparam logic [KW-1:0] LAST_K   = KW'(K - 1);

    logic [2:0]               state;
    logic [AW-1:0]            idx;
    logic [KW-1:0]            kidx;
    logic [K-1:0][SW-1:0]     sum;
    logic [K-1:0][CW-1:0]     cnt;
    logic [DW-1:0]            point_reg;
    logic [DW-1:0]            quot;
    logic                     changed;
    logic                     conv_r;
    logic [IW-1:0]            iters;
    logic [IW-1:0]            iter_next;
    logic                     cur_empty;
    logic                     last_k;
    logic [DW-1:0]            cur_cent;

    assign iter_next = iters + 1'b1;
    assign cur_empty = (cnt[kidx] == '0);
    assign last_k    = (kidx == LAST_K);
    assign cur_cent  = cent_q[int'(kidx)*DW +: DW];

    // All strobes decode from state, so at most one can be active per cycle.
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);
    assign converged    = conv_r;
    assign iter_count   = iters;
    assign point_rd     = (state == S_FETCH);
    assign point_addr   = idx;
    assign dist_req     = (state == S_DIST);
    assign dist_point   = point_reg;
    assign div_req      = (state == S_DIVREQ) && !cur_empty;
    assign div_dividend = sum[kidx];
    assign div_divisor  = cnt[kidx];
    assign cent_we      = (state == S_UPDATE) ? (K'(1) << kidx) : '0;
    assign cent_wdata   = quot;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            kidx      <= '0;
            sum       <= '0;
            cnt       <= '0;
            point_reg <= '0;
            quot      <= '0;
            changed   <= 1'b0;
            conv_r    <= 1'b0;
            iters     <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    sum     <= '0;
                    cnt     <= '0;
                    changed <= 1'b0;
                    conv_r  <= 1'b0;
                    iters   <= '0;
                    idx     <= '0;
                    kidx    <= '0;
                    state   <= S_FETCH;
                end
                S_FETCH: state <= S_WAITD;
                S_WAITD: begin
                    point_reg <= point_data;
                    state     <= S_DIST;
                end
                S_DIST: if (dist_ack) begin
                    // Out-of-range ids are dropped without touching the accumulators.
                    if (32'(dist_id) < K) begin
                        sum[dist_id] <= sum[dist_id] + SW'(point_reg);
                        cnt[dist_id] <= cnt[dist_id] + 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        kidx  <= '0;
                        state <= S_DIVREQ;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_DIVREQ: begin
                    if (cur_empty) begin
                        kidx  <= last_k ? '0 : kidx + 1'b1;
                        state <= last_k ? S_CHECK : S_DIVREQ;
                    end else if (div_ack) begin
                        quot  <= div_quot;
                        state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    // cent_q still holds the old value this cycle; the write lands next edge.
                    changed <= changed | (quot != cur_cent);
                    kidx    <= last_k ? '0 : kidx + 1'b1;
                    state   <= last_k ? S_CHECK : S_DIVREQ;
                end
                S_CHECK: begin
                    iters <= iter_next;
                    if (!changed || iter_next == IW'(MAX_ITER)) begin
                        conv_r <= !changed;
                        state  <= S_DONE;
                    end else begin
                        sum     <= '0;
                        cnt     <= '0;
                        changed <= 1'b0;
                        idx     <= '0;
                        state   <= S_FETCH;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// Bench for kmeans_iter_ctrl: a responder environment (point memory, nearest-centroid unit,
// divider, centroid bank) plus a pass-level K-means reference model.
module tb_kmeans_iter_ctrl;

    localparam int K  = 2;
    localparam int NP = 4;
    localparam int DW = 32;
    localparam int AW = 2;
    localparam int KW = 1;
    localparam int SW = DW + AW;
    localparam int CW = AW + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic sel = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0]   point_data;
    logic            dist_ack, div_ack;
    logic [KW-1:0]   dist_id;
    logic [DW-1:0]   div_quot;
    logic [K*DW-1:0] cent_q;

    logic busy0, done0, conv0, prd0, dreq0, vreq0;
    logic busy1, done1, conv1, prd1, dreq1, vreq1;
    logic [4:0] iter0;
    logic [1:0] iter1;
    logic [AW-1:0] paddr0, paddr1;
    logic [DW-1:0] dpt0, dpt1, wdata0, wdata1;
    logic [SW-1:0] dvd0, dvd1;
    logic [CW-1:0] dvs0, dvs1;
    logic [K-1:0]  we0, we1;

    logic busy, done, converged, point_rd, dist_req, div_req;
    logic [4:0]    iter_count;
    logic [AW-1:0] point_addr;
    logic [DW-1:0] dist_point, cent_wdata;
    logic [SW-1:0] div_dividend;
    logic [CW-1:0] div_divisor;
    logic [K-1:0]  cent_we;

    kmeans_iter_ctrl #(.K(K), .N_POINTS(NP), .DW(DW), .MAX_ITER(16)) u_dut (
        .clk(clk), .reset(reset), .start(start && !sel),
        .busy(busy0), .done(done0), .converged(conv0), .iter_count(iter0),
        .point_rd(prd0), .point_addr(paddr0), .point_data(point_data),
        .dist_req(dreq0), .dist_point(dpt0), .dist_ack(dist_ack), .dist_id(dist_id),
        .div_req(vreq0), .div_dividend(dvd0), .div_divisor(dvs0), .div_ack(div_ack), .div_quot(div_quot),
        .cent_q(cent_q), .cent_we(we0), .cent_wdata(wdata0)
    );

    kmeans_iter_ctrl #(.K(K), .N_POINTS(NP), .DW(DW), .MAX_ITER(2)) u_lim (
        .clk(clk), .reset(reset), .start(start && sel),
        .busy(busy1), .done(done1), .converged(conv1), .iter_count(iter1),
        .point_rd(prd1), .point_addr(paddr1), .point_data(point_data),
        .dist_req(dreq1), .dist_point(dpt1), .dist_ack(dist_ack), .dist_id(dist_id),
        .div_req(vreq1), .div_dividend(dvd1), .div_divisor(dvs1), .div_ack(div_ack), .div_quot(div_quot),
        .cent_q(cent_q), .cent_we(we1), .cent_wdata(wdata1)
    );

    // Only one instance runs at a time; the environment serves the selected one.
    assign busy         = sel ? busy1 : busy0;
    assign done         = sel ? done1 : done0;
    assign converged    = sel ? conv1 : conv0;
    assign iter_count   = sel ? {3'b0, iter1} : iter0;
    assign point_rd     = sel ? prd1 : prd0;
    assign point_addr   = sel ? paddr1 : paddr0;
    assign dist_req     = sel ? dreq1 : dreq0;
    assign dist_point   = sel ? dpt1 : dpt0;
    assign div_req      = sel ? vreq1 : vreq0;
    assign div_dividend = sel ? dvd1 : dvd0;
    assign div_divisor  = sel ? dvs1 : dvs0;
    assign cent_we      = sel ? we1 : we0;
    assign cent_wdata   = sel ? wdata1 : wdata0;

    logic [DW-1:0] pmem [NP];
    logic [DW-1:0] cent [K];
    logic [DW-1:0] cent_init [K];
    logic cent_load = 1'b0;
    int   ddly = 0, vdly = 0, dcnt = 0, vcnt = 0;
    bit   force0 = 1'b0;
    longint bd, dd;

    function automatic longint ad(input longint a, input longint b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Read data is only meaningful the cycle after point_rd; junk otherwise.
    always @(posedge clk) begin
        point_data <= point_rd ? pmem[point_addr] : $urandom;
        dcnt <= (reset || !dist_req || dist_ack) ? 0 : dcnt + 1;
        vcnt <= (reset || !div_req || div_ack) ? 0 : vcnt + 1;
        if (cent_load) cent <= cent_init;
        else for (int k = 0; k < K; k++) if (cent_we[k]) cent[k] <= cent_wdata;
    end

    always_comb begin
        for (int k = 0; k < K; k++) cent_q[k*DW +: DW] = cent[k];
    end

    assign dist_ack = dist_req && (dcnt >= ddly);
    assign div_ack  = div_req && (vcnt >= vdly);
    assign div_quot = (div_divisor != 0) ? DW'(div_dividend / div_divisor) : '0;

    always_comb begin
        dist_id = '0;
        bd = ad(longint'(dist_point), longint'(cent[0]));
        dd = 0;
        for (int k = 1; k < K; k++) begin
            dd = ad(longint'(dist_point), longint'(cent[k]));
            if (!force0 && dd < bd) begin
                bd = dd;
                dist_id = KW'(k);
            end
        end
    end

    int nvec = 0, nerr = 0;
    int rd_seq = 0, div_n = 0, mid_at = -1;
    logic [SW-1:0] last_dvd;
    logic [CW-1:0] last_dvs;
    int wk[$];
    longint wv[$];
    int ewk[$];
    longint ewv[$];
    longint efin [K];
    int eiter;
    bit econv;
    logic p_rd = 0, p_dreq = 0, p_dack = 0, p_vreq = 0, p_vack = 0;
    logic [DW-1:0] p_dpt;
    logic [SW-1:0] p_dvd;
    logic [CW-1:0] p_dvs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One cycle: wait for the falling edge, then run the protocol monitors.
    task automatic tick();
        @(negedge clk);
        if (reset) begin
            p_rd = 0; p_dreq = 0; p_dack = 0; p_vreq = 0; p_vack = 0;
        end else begin
            chk("exclusive", ($countones({point_rd, dist_req, div_req, |cent_we}) <= 1), 1);
            if (p_rd) chk("rd_pulse", point_rd, 0);
            if (point_rd) begin
                chk("rd_addr", point_addr, rd_seq % NP);
                rd_seq++;
            end
            if (p_dreq && !p_dack) begin
                chk("dist_req_hold", dist_req, 1);
                chk("dist_point_hold", dist_point, p_dpt);
            end
            if (p_vreq && !p_vack) begin
                chk("div_req_hold", div_req, 1);
                chk("dividend_hold", div_dividend, p_dvd);
                chk("divisor_hold", div_divisor, p_dvs);
            end
            if (div_req && div_ack) begin
                div_n++;
                last_dvd = div_dividend;
                last_dvs = div_divisor;
            end
            if (cent_we != '0) begin
                chk("we_onehot", $onehot(cent_we), 1);
                for (int k = 0; k < K; k++) if (cent_we[k]) wk.push_back(k);
                wv.push_back(longint'(cent_wdata));
            end
            p_rd = point_rd; p_dreq = dist_req; p_dack = dist_ack; p_vreq = div_req; p_vack = div_ack;
            p_dpt = dist_point; p_dvd = div_dividend; p_dvs = div_divisor;
        end
    endtask

    // Pass-level K-means: nearest centroid (ties to lower id) or all-to-zero,
    // truncating mean per non-empty cluster, stop when stable or at the pass limit.
    task automatic model(input int maxit);
        longint c [K];
        longint s [K];
        int n [K];
        longint p, q, best, d;
        int id;
        bit ch;
        for (int k = 0; k < K; k++) c[k] = cent_init[k];
        ewk.delete(); ewv.delete();
        eiter = 0;
        ch = 1;
        for (int pass = 0; pass < maxit; pass++) begin
            for (int k = 0; k < K; k++) begin s[k] = 0; n[k] = 0; end
            for (int i = 0; i < NP; i++) begin
                p = pmem[i];
                id = 0;
                best = ad(p, c[0]);
                for (int k = 1; k < K; k++) begin
                    d = ad(p, c[k]);
                    if (!force0 && d < best) begin best = d; id = k; end
                end
                s[id] += p;
                n[id]++;
            end
            ch = 0;
            for (int k = 0; k < K; k++) if (n[k] > 0) begin
                q = s[k] / n[k];
                ewk.push_back(k);
                ewv.push_back(q);
                if (q != c[k]) ch = 1;
                c[k] = q;
            end
            eiter = pass + 1;
            if (!ch) break;
        end
        econv = !ch;
        for (int k = 0; k < K; k++) efin[k] = c[k];
    endtask

    task automatic set_pts(input logic [DW-1:0] a, b, c, d);
        pmem[0] = a; pmem[1] = b; pmem[2] = c; pmem[3] = d;
    endtask

    task automatic set_cent(input logic [DW-1:0] a, b);
        cent_init[0] = a; cent_init[1] = b;
    endtask

    task automatic load_cent();
        cent_load = 1'b1;
        tick();
        cent_load = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int n = 0; n < 3000; n++) begin
            start = (n == mid_at);
            tick();
            if (done) begin ok = 1; break; end
        end
        start = 1'b0;
    endtask

    task automatic run_case(input string name, input int maxit);
        bit ok;
        model(maxit);
        load_cent();
        wk.delete(); wv.delete();
        div_n = 0;
        rd_seq = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({name, "_busy_after_start"}, busy, 1);
        wait_done(ok);
        chk({name, "_done_seen"}, ok, 1);
        if (ok) begin
            chk({name, "_converged"}, converged, econv);
            chk({name, "_iter_count"}, iter_count, eiter);
            chk({name, "_busy_in_done"}, busy, 1);
            tick();
            chk({name, "_done_pulse"}, done, 0);
            chk({name, "_busy_after"}, busy, 0);
            chk({name, "_conv_held"}, converged, econv);
            chk({name, "_iter_held"}, iter_count, eiter);
            chk({name, "_n_writes"}, wv.size(), ewv.size());
            for (int i = 0; i < wv.size() && i < ewv.size(); i++) begin
                chk({name, "_wr_cluster"}, wk[i], ewk[i]);
                chk({name, "_wr_value"}, wv[i], ewv[i]);
            end
            chk({name, "_n_divides"}, div_n, ewv.size());
            chk({name, "_n_reads"}, rd_seq, eiter * NP);
            for (int k = 0; k < K; k++) chk({name, "_final_cent"}, cent[k], efin[k]);
        end
    endtask

    initial begin
        bit ok;
        int n0;
        repeat (2) tick();
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_conv", conv0, 0);
        chk("rst_iter", iter0, 0);
        chk("rst_point_rd", prd0, 0);
        chk("rst_point_addr", paddr0, 0);
        chk("rst_dist_req", dreq0, 0);
        chk("rst_div_req", vreq0, 0);
        chk("rst_cent_we", we0, 0);
        chk("rst_cent_wdata", wdata0, 0);
        reset = 1'b0;
        tick();

        // Convergence in three passes.
        set_pts(1, 2, 10, 12); set_cent(0, 20);
        run_case("conv", 16);
        chk("conv_iter_const", iter_count, 3);
        chk("conv_flag_const", converged, 1);
        if (wv.size() == 6) begin
            chk("conv_p1c0", wv[0], 4);  chk("conv_p1c1", wv[1], 12);
            chk("conv_p2c0", wv[2], 1);  chk("conv_p2c1", wv[3], 11);
            chk("conv_p3c0", wv[4], 1);  chk("conv_p3c1", wv[5], 11);
        end else chk("conv_wr_count", wv.size(), 6);

        // Pass limit on the MAX_ITER=2 instance.
        sel = 1'b1;
        run_case("limit", 2);
        chk("limit_iter_const", iter_count, 2);
        chk("limit_conv_const", converged, 0);
        if (wv.size() == 4) begin
            chk("limit_last_c0", wv[2], 1);
            chk("limit_last_c1", wv[3], 11);
        end else chk("limit_wr_count", wv.size(), 4);
        sel = 1'b0;

        // Empty cluster: everything lands in cluster 0.
        force0 = 1'b1;
        set_pts(4, 4, 4, 4); set_cent(0, 9);
        run_case("empty", 16);
        chk("empty_iter_const", iter_count, 2);
        chk("empty_conv_const", converged, 1);
        chk("empty_divides", div_n, 2);
        chk("empty_dividend", last_dvd, 16);
        chk("empty_divisor", last_dvs, 4);
        chk("empty_c1_kept", cent[1], 9);
        foreach (wk[i]) chk("empty_we_only_c0", wk[i], 0);
        force0 = 1'b0;

        // Back-pressure on both handshakes, with a stray start mid-run.
        ddly = 5; vdly = 5; mid_at = 30;
        set_pts(1, 2, 10, 12); set_cent(0, 20);
        run_case("bp", 16);
        chk("bp_iter_const", iter_count, 3);
        chk("bp_conv_const", converged, 1);
        mid_at = -1;

        // Reset while a divide request is pending.
        vdly = 4; ddly = 1;
        load_cent();
        wk.delete(); wv.delete();
        start = 1'b1; tick(); start = 1'b0;
        ok = 0;
        for (int n = 0; n < 500; n++) begin
            tick();
            if (div_req) begin ok = 1; break; end
        end
        chk("rstmid_div_req_seen", ok, 1);
        n0 = wv.size();
        reset = 1'b1;
        tick();
        chk("rstmid_busy", busy, 0);
        chk("rstmid_div_req", div_req, 0);
        chk("rstmid_cent_we", cent_we, 0);
        chk("rstmid_iter", iter_count, 0);
        reset = 1'b0;
        repeat (8) tick();
        chk("rstmid_no_write", wv.size(), n0);
        chk("rstmid_idle", busy, 0);
        run_case("rerun", 16);
        chk("rerun_iter_const", iter_count, 3);
        chk("rerun_conv_const", converged, 1);

        // Randomized runs against the model.
        for (int r = 0; r < 10; r++) begin
            sel = 1'($urandom_range(0, 1));
            force0 = ($urandom_range(0, 4) == 0);
            ddly = $urandom_range(0, 3);
            vdly = $urandom_range(0, 3);
            set_pts($urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 255));
            set_cent($urandom_range(0, 255), $urandom_range(0, 255));
            run_case("rand", sel ? 2 : 16);
        end
        sel = 1'b0;

        // Near-full-scale points: the sum needs the extra AW bits.
        force0 = 1'b1; ddly = 0; vdly = 0;
        set_pts(32'hFFFF_FFF0, 32'hFFFF_FFF1, 32'hFFFF_FFF2, 32'hFFFF_FFF3);
        set_cent(0, 5);
        run_case("wide", 16);
        chk("wide_dividend", last_dvd, 34'h3_FFFF_FFC6);
        chk("wide_quot", cent[0], 32'hFFFF_FFF1);
        force0 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/kmeans_iter_ctrl.md
Name: kmeans_iter_ctrl

Overview:
Iteration sequencer for 1-D K-means clustering over DW-bit unsigned points. Per pass it streams every point from point memory to the external distance/assign unit, accumulates per-cluster sums and counts, then uses an external divider to compute new centroids. It writes each new centroid into the 32-bit centroid register bank and repeats until no centroid changes or MAX_ITER passes have run.

Parameters:
K, 4, number of clusters (>=2)
N_POINTS, 64, points per pass (>=2)
DW, 32, point/centroid width
MAX_ITER, 16, pass limit (>=1)
Derived: AW=clog2(N_POINTS), KW=clog2(K), SW=DW+AW (sum width), CW=AW+1 (count width)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  begin run; sampled only in IDLE
busy  out  1  high from the cycle after accepted start until DONE exits
done  out  1  one-cycle pulse at run end
converged  out  1  valid with done, held until next start: 1 = last pass changed nothing
iter_count  out  clog2(MAX_ITER+1)  completed passes, held after done
point_rd  out  1  point memory read strobe
point_addr  out  AW  read address
point_data  in  DW  read data, valid exactly 1 cycle after point_rd
dist_req  out  1  point offered to distance unit
dist_point  out  DW  point value
dist_ack  in  1  assignment accepted
dist_id  in  KW  nearest cluster index, valid with dist_ack
div_req  out  1  divide request
div_dividend  out  SW  cluster sum
div_divisor  out  CW  cluster count
div_ack  in  1  quotient valid
div_quot  in  DW  sum/count
cent_q  in  K*DW  current centroids, cluster k at bits [k*DW +: DW]
cent_we  out  K  one-hot centroid register write enable
cent_wdata  out  DW  new centroid value

Behaviour:
- Reset: state IDLE; busy, done, converged, point_rd, dist_req, div_req, cent_we = 0; iter_count, point_addr, cent_wdata, sums, counts, indices = 0. Reset at any point aborts the run; outstanding requests drop on the next edge and no write follows.
- States: IDLE, FETCH, WAITD, DIST, DIVREQ, UPDATE, CHECK, DONE.
- IDLE: on start, clear sums/counts/changed/iter_count/idx and go to FETCH. start is ignored in all other states.
- FETCH: point_rd=1, point_addr=idx for exactly one cycle, then WAITD.
- WAITD: capture point_data into point_reg, then DIST.
- DIST: dist_req=1 and dist_point=point_reg, held stable until dist_ack; ack in the first cycle is legal. On ack with dist_id<K: sum[dist_id]+=point_reg, cnt[dist_id]+=1. An out-of-range dist_id is dropped without accumulation. Then, if idx==N_POINTS-1, set kidx=0 and go to DIVREQ; else idx+1 and go to FETCH.
- DIVREQ for cluster kidx:
  - If cnt==0: no request, no write, centroid keeps its value; advance kidx.
  - Else: div_req=1 with dividend=sum[kidx] and divisor=cnt[kidx], held until div_ack. On ack, latch quotient and go to UPDATE.
- UPDATE: cent_we[kidx]=1 for one cycle with cent_wdata=quotient. changed |= (quotient != cent_q[kidx]), compared before the write lands. Advance kidx; go to DIVREQ, or to CHECK after cluster K-1.
- CHECK: iter_count+1. If changed==0 or iter_count==MAX_ITER, go to DONE; else clear sums/counts/changed/idx and go to FETCH.
- DONE: done=1 for one cycle, converged=!changed, busy drops the following cycle, then IDLE.
- Width: sums are SW bits and cannot overflow (N_POINTS*(2^DW-1)). The divide result is truncating and comes from the divider.
- At most one of point_rd, dist_req, div_req, cent_we is active in any cycle.

Test Plan:
- Convergence, K=2, N_POINTS=4, points {1,2,10,12}, initial cent_q {0,20}, nearest-distance model with ties to lower id:
  - Pass 1 writes {4,12}; pass 2 writes {1,11}; pass 3 writes {1,11}.
  - Required: done with converged=1 and iter_count=3.
- Pass limit: same data with MAX_ITER=2 -> done after pass 2 with converged=0, iter_count=2, last write {1,11}.
- Empty cluster: model always returns dist_id=0 for points {4,4,4,4} and cent_q {0,9}.
  - Required: one div_req per pass (dividend 16, divisor 4), cent_we only ever 2'b01.
  - Pass 2 is unchanged, so converged=1 and iter_count=2.
- Back-pressure: dist_ack and div_ack each delayed 5 cycles.
  - Required: dist_point, dist_req, div_req and operands stay stable while waiting; results match the convergence run.
  - A start pulse mid-run is ignored.
- Read sequencing: each pass issues exactly N_POINTS single-cycle point_rd pulses with addresses 0..N_POINTS-1 in order; data is captured 1 cycle later.
- Reset mid-run: assert reset while div_req is high.
  - Required: next cycle busy=0, div_req=0, cent_we=0, iter_count=0, and no centroid write.
  - A new start then reruns from address 0 and reproduces the convergence result.
